// File: rtl/sdram_read_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sdram_read_ctrl
//
// Read-path engine of the SDRAM controller. Each request runs one
// full-page-mode burst read:
//   ACTIVE -> tRCD wait -> READ -> data/BURST STOP -> PRECHARGE -> tRP -> end.
// The SDRAM mode register is expected to be set for full-page burst with
// CAS latency CL_CLK. An upstream arbiter muxes cmd/bank/addr onto the pins.
//
// Parameters
//   TRCD_CLK  ACTIVE-to-READ delay in clocks (>= 1)
//   TRP_CLK   PRECHARGE recovery in clocks (>= 1)
//   CL_CLK    CAS latency in clocks (>= 1), must match the mode register
//
// Ports
//   sys_clk        controller clock (same as the SDRAM clock)
//   sys_rst_n      asynchronous active-low reset
//   init_end       SDRAM initialisation complete (level)
//   rd_en          read request level, held until rd_end
//   rd_addr        {bank[23:22], row[21:9], column[8:0]}, held until rd_end
//   rd_burst_len   words to read, 1..512 (0 is treated as 1), held until rd_end
//   rd_sdram_data  SDRAM DQ bus
//   rd_ack         rd_data_out carries a valid word this cycle
//   rd_end         one-cycle pulse when the burst sequence has finished
//   rd_sdram_cmd   {CS_n, RAS_n, CAS_n, WE_n}
//   rd_sdram_bank  bank address
//   rd_sdram_addr  address bus
//   rd_data_out    read word, 0 when rd_ack is low
// -----------------------------------------------------------------------------
module sdram_read_ctrl #(
  parameter int TRCD_CLK = 2,
  parameter int TRP_CLK  = 2,
  parameter int CL_CLK   = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr,
  output logic [15:0] rd_data_out
);

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;

  localparam logic [1:0]  BANK_IDLE = 2'b11;
  localparam logic [12:0] ADDR_IDLE = 13'h1FFF;
  localparam logic [12:0] ADDR_PALL = 13'h0400;  // A10 = 1: all banks

  // Counter must reach CL_CLK + 512 - 1 during the data phase.
  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] TRCD_LAST = CNT_W'(TRCD_CLK - 1);
  localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP_CLK - 1);
  localparam logic [CNT_W-1:0] ACK_FIRST = CNT_W'(CL_CLK);
  localparam logic [CNT_W-1:0] CL_M2     = CNT_W'(CL_CLK - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_TRCD,
    S_READ,
    S_DATA,
    S_PRE,
    S_TRP,
    S_END
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       data_p0;

  logic [CNT_W-1:0]  burst_len;
  logic [CNT_W-1:0]  stop_cnt;
  logic [CNT_W-1:0]  data_last;

  // Effective burst length and the counter values derived from it.
  always_comb begin
    burst_len = (rd_burst_len == 10'd0) ? CNT_W'(1) : {1'b0, rd_burst_len};
    stop_cnt  = burst_len - CNT_W'(1);
    // The last word leaves the capture register in the counter slot
    // CL_CLK + L - 1. PRECHARGE is issued in that same slot (the word has
    // already been taken off DQ), so DATA hands over to PRE one count earlier
    // and PRE keeps rd_ack high for the final word.
    data_last = burst_len + CL_M2;
  end

  // ---------------------------------------------------------------------------
  // Control: state and shared wait/data counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (init_end && rd_en) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          cnt   <= '0;
          state <= S_TRCD;
        end
        S_TRCD: begin
          if (cnt == TRCD_LAST) begin
            cnt   <= '0;
            state <= S_READ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          cnt   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == data_last) state <= S_PRE;
        end
        S_PRE: begin
          cnt   <= '0;
          state <= S_TRP;
        end
        S_TRP: begin
          if (cnt == TRP_LAST) begin
            cnt   <= '0;
            state <= S_END;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_END: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: DQ capture register, free-running every clock
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) data_p0 <= '0;
    else            data_p0 <= rd_sdram_data;
  end

  // ---------------------------------------------------------------------------
  // Output decode from current state and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_sdram_cmd  = CMD_NOP;
    rd_sdram_bank = BANK_IDLE;
    rd_sdram_addr = ADDR_IDLE;
    rd_ack        = 1'b0;
    rd_end        = 1'b0;
    case (state)
      S_ACTIVE: begin
        rd_sdram_cmd  = CMD_ACTIVE;
        rd_sdram_bank = rd_addr[23:22];
        rd_sdram_addr = rd_addr[21:9];
      end
      S_READ: begin
        rd_sdram_cmd  = CMD_READ;
        rd_sdram_bank = rd_addr[23:22];
        rd_sdram_addr = {4'b0000, rd_addr[8:0]};
      end
      S_DATA: begin
        if (cnt == stop_cnt) rd_sdram_cmd = CMD_BURST_STOP;
        rd_ack = (cnt >= ACK_FIRST);
      end
      S_PRE: begin
        rd_sdram_cmd  = CMD_PRECHARGE;
        rd_sdram_addr = ADDR_PALL;
        rd_ack        = 1'b1;
      end
      S_END: begin
        rd_end = 1'b1;
      end
      default: begin
      end
    endcase
    rd_data_out = rd_ack ? data_p0 : 16'h0000;
  end

endmodule

// File: tb/tb_sdram_read_ctrl.sv
`timescale 1ns/1ps
module tb_sdram_read_ctrl;

  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int CL   = 3;
  localparam int R_OFF = TRCD + 1;   // READ offset from the ACTIVE cycle

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_RD   = 4'b0101;
  localparam logic [3:0] C_BST  = 4'b0110;
  localparam logic [3:0] C_PRE  = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        rd_en = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  rd_burst_len = '0;
  logic [15:0] rd_sdram_data = '0;
  logic        rd_ack;
  logic        rd_end;
  logic [3:0]  rd_sdram_cmd;
  logic [1:0]  rd_sdram_bank;
  logic [12:0] rd_sdram_addr;
  logic [15:0] rd_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [512];
  logic [15:0] dq_hist [2048];

  always #5 sys_clk = ~sys_clk;

  sdram_read_ctrl #(
    .TRCD_CLK(TRCD),
    .TRP_CLK (TRP),
    .CL_CLK  (CL)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_sdram_data(rd_sdram_data),
    .rd_ack       (rd_ack),
    .rd_end       (rd_end),
    .rd_sdram_cmd (rd_sdram_cmd),
    .rd_sdram_bank(rd_sdram_bank),
    .rd_sdram_addr(rd_sdram_addr),
    .rd_data_out  (rd_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cmd"},  32'(rd_sdram_cmd),  32'(C_NOP));
    check({tag, " bank"}, 32'(rd_sdram_bank), 32'h3);
    check({tag, " addr"}, 32'(rd_sdram_addr), 32'h1FFF);
    check({tag, " ack"},  32'(rd_ack),        32'h0);
    check({tag, " end"},  32'(rd_end),        32'h0);
    check({tag, " data"}, 32'(rd_data_out),   32'h0);
  endtask

  task automatic fill_random_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
  endtask

  // One request, checked cycle by cycle against the timeline implied by the
  // command rules. t = 0 is the cycle ACTIVE is expected on the bus.
  // abort_t >= 0 asserts reset at that cycle and then stops the request.
  task automatic run_burst(input logic [23:0] addr, input logic [9:0] len, input int abort_t);
    int L, col, t_stop, t_pre, t_end, last, k;
    logic [3:0]  e_cmd;
    logic [1:0]  e_bank;
    logic [12:0] e_addr;
    logic        e_ack, e_end;
    logic [15:0] e_data;
    L      = (len == 10'd0) ? 1 : int'(len);
    col    = int'(addr[8:0]);
    t_stop = R_OFF + L;
    t_pre  = R_OFF + CL + L;
    t_end  = t_pre + TRP + 1;
    last   = (abort_t >= 0) ? abort_t : t_end + 3;

    @(negedge sys_clk);
    rd_addr       = addr;
    rd_burst_len  = len;
    rd_en         = 1'b1;
    rd_sdram_data = 16'($urandom);

    for (int t = 0; t <= last; t++) begin
      @(negedge sys_clk);
      e_cmd  = C_NOP;
      e_bank = 2'b11;
      e_addr = 13'h1FFF;
      if (t == 0) begin
        e_cmd = C_ACT; e_bank = addr[23:22]; e_addr = addr[21:9];
      end else if (t == R_OFF) begin
        e_cmd = C_RD; e_bank = addr[23:22]; e_addr = {4'b0, addr[8:0]};
      end else if (t == t_stop) begin
        e_cmd = C_BST;
      end else if (t == t_pre) begin
        e_cmd = C_PRE; e_addr = 13'h0400;
      end
      e_ack  = (t >= R_OFF + CL + 1) && (t <= R_OFF + CL + L);
      e_end  = (t == t_end);
      e_data = e_ack ? dq_hist[t-1] : 16'h0000;

      check($sformatf("cmd t=%0d", t),  32'(rd_sdram_cmd),  32'(e_cmd));
      check($sformatf("bank t=%0d", t), 32'(rd_sdram_bank), 32'(e_bank));
      check($sformatf("addr t=%0d", t), 32'(rd_sdram_addr), 32'(e_addr));
      check($sformatf("ack t=%0d", t),  32'(rd_ack),        32'(e_ack));
      check($sformatf("end t=%0d", t),  32'(rd_end),        32'(e_end));
      check($sformatf("data t=%0d", t), 32'(rd_data_out),   32'(e_data));

      // Bank model: word k of the burst is on DQ in cycle R + CL + k.
      k = t - (R_OFF + CL);
      if (k >= 0 && k < L) rd_sdram_data = mem[(col + k) % 512];
      else                 rd_sdram_data = 16'($urandom);
      dq_hist[t] = rd_sdram_data;

      if (t == t_end) rd_en = 1'b0;

      if (t == abort_t) begin
        sys_rst_n = 1'b0;
        #1;
        check_idle("abort_now");
        @(negedge sys_clk);
        check_idle("abort_next");
        rd_en     = 1'b0;
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge sys_clk);
          check_idle("post_abort");
        end
      end
    end
  endtask

  initial begin
    // Reset held with a request pending but init not done.
    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    rd_en     = 1'b1;
    rd_sdram_data = 16'hBEEF;
    repeat (3) @(negedge sys_clk);
    check_idle("reset");
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      rd_sdram_data = 16'($urandom);
      check_idle("no_init");
    end
    rd_en    = 1'b0;
    init_end = 1'b1;
    @(negedge sys_clk);
    check_idle("init_idle");

    // Full page from address 0, bank preloaded with 0..511.
    for (int i = 0; i < 512; i++) mem[i] = 16'(i);
    run_burst(24'h000000, 10'd512, -1);

    // Short burst, bank 3, row 5, column 5.
    fill_random_mem();
    run_burst(24'hC00A05, 10'd4, -1);

    // Minimum lengths.
    run_burst(24'($urandom), 10'd1, -1);
    run_burst(24'($urandom), 10'd0, -1);

    // Reset during the data phase, then a full request afterwards.
    fill_random_mem();
    run_burst(24'($urandom), 10'd16, R_OFF + CL + 3);
    run_burst(24'($urandom), 10'd24, -1);

    // Random requests.
    for (int n = 0; n < 4; n++) begin
      fill_random_mem();
      run_burst(24'($urandom), 10'($urandom_range(0, 512)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
